// File: rtl/frame_loader_pkg.sv
// Shared constants, state encoding and header test for the configuration frame loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package frame_loader_pkg;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;
  localparam logic [7:0]  HEADER_MARK = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNCED = 2'd1,
    ST_DATA   = 2'd2,
    ST_STROBE = 2'd3
  } state_t;

  // A frame header is any word carrying the marker in its top byte.
  function automatic logic is_header(input logic [31:0] word);
    return word[31:24] == HEADER_MARK;
  endfunction

endpackage

// File: rtl/config_sync_detect.sv
// Purpose: flags whether the incoming configuration word is the SYNC or DESYNC marker.
// Latency: combinational, zero cycles.
// Backpressure: none; the result is only meaningful in cycles where the caller has a strobed word.
// Ports:
//   write_data : configuration word under test
//   is_sync    : word equals SYNC_WORD
//   is_desync  : word equals DESYNC_WORD
module config_sync_detect
  import frame_loader_pkg::*;
#(
  parameter int FrameBitsPerRow = 32
) (
  input  logic [FrameBitsPerRow-1:0] write_data,
  output logic                       is_sync,
  output logic                       is_desync
);

  assign is_sync   = (write_data == SYNC_WORD);
  assign is_desync = (write_data == DESYNC_WORD);

endmodule

// File: rtl/config_frame_loader.sv
// Purpose: turns a strobed configuration word stream (SYNC, header, N data words) into row writes plus a frame strobe.
// Latency: data word in cycle t appears on FrameData_O/RowSelect in t+1; last word at t gives FrameStrobe in t+2.
// Backpressure: none; every strobed word is consumed in the cycle it is presented.
// Ports:
//   CLK, resetn               : clock and synchronous active-low reset
//   WriteData, WriteStrobe    : incoming word and its one-cycle qualifier
//   FrameData_O, RowSelect    : registered row write (RowSelect 0 = no row)
//   ColumnSelect, FrameSelect : frame address captured from the header
//   FrameStrobe, Synced, Error: frame commit pulse, link synced, sticky protocol error
//   FrameCount                : completed frames, saturating (only with FRAME_LOADER_FRAMECNT_EN)
// Optional build macro: FRAME_LOADER_FRAMECNT_EN adds the FrameCount output and its counter.
module config_frame_loader
  import frame_loader_pkg::*;
#(
  parameter int FrameBitsPerRow   = 32,
  parameter int RowSelectWidth    = 5,
  parameter int NumberOfRows      = 16,
  parameter int ColumnSelectWidth = 5,
  parameter int FrameSelectWidth  = 5
) (
  input  logic                         CLK,
  input  logic                         resetn,
  input  logic [FrameBitsPerRow-1:0]   WriteData,
  input  logic                         WriteStrobe,
  output logic [FrameBitsPerRow-1:0]   FrameData_O,
  output logic [RowSelectWidth-1:0]    RowSelect,
  output logic [ColumnSelectWidth-1:0] ColumnSelect,
  output logic [FrameSelectWidth-1:0]  FrameSelect,
  output logic                         FrameStrobe,
  output logic                         Synced,
  output logic                         Error
`ifdef FRAME_LOADER_FRAMECNT_EN
  ,
  output logic [15:0]                  FrameCount
`endif
);

  localparam logic [RowSelectWidth-1:0] FirstRow = RowSelectWidth'(1);
  localparam logic [RowSelectWidth-1:0] LastRow  = RowSelectWidth'(NumberOfRows);

  state_t state_q, state_d;
  logic [RowSelectWidth-1:0]    row_cnt_q, row_cnt_d;
  logic [RowSelectWidth-1:0]    row_sel_d;
  logic [FrameBitsPerRow-1:0]   frame_data_d;
  logic [ColumnSelectWidth-1:0] col_sel_d;
  logic [FrameSelectWidth-1:0]  frame_sel_d;
  logic                         frame_strobe_d;
  logic                         error_d;

  logic is_sync, is_desync, hdr;

  config_sync_detect #(
    .FrameBitsPerRow(FrameBitsPerRow)
  ) u_sync_detect (
    .write_data(WriteData),
    .is_sync   (is_sync),
    .is_desync (is_desync)
  );

  assign hdr = is_header(WriteData);

  // State register plus all registered outputs.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      row_cnt_q    <= FirstRow;
      RowSelect    <= '0;
      FrameData_O  <= '0;
      ColumnSelect <= '0;
      FrameSelect  <= '0;
      FrameStrobe  <= 1'b0;
      Error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      RowSelect    <= row_sel_d;
      FrameData_O  <= frame_data_d;
      ColumnSelect <= col_sel_d;
      FrameSelect  <= frame_sel_d;
      FrameStrobe  <= frame_strobe_d;
      Error        <= error_d;
    end
  end

  // Next-state logic. The single STROBE cycle behaves like SYNCED for incoming
  // words so a header may follow the last data word immediately.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (WriteStrobe && is_sync) state_d = ST_SYNCED;
      end
      ST_SYNCED, ST_STROBE: begin
        state_d = ST_SYNCED;
        if (WriteStrobe) begin
          if (is_desync)  state_d = ST_IDLE;
          else if (hdr)   state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (WriteStrobe && (row_cnt_q == LastRow)) state_d = ST_STROBE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values. RowSelect defaults to 0 so it is only
  // non-zero in the cycle after an accepted data word; FrameData_O holds.
  always_comb begin
    row_sel_d      = '0;
    row_cnt_d      = row_cnt_q;
    frame_data_d   = FrameData_O;
    col_sel_d      = ColumnSelect;
    frame_sel_d    = FrameSelect;
    error_d        = Error;
    // Registering the STROBE state puts the pulse two cycles after the last word.
    frame_strobe_d = (state_q == ST_STROBE);
    unique case (state_q)
      ST_IDLE: ;
      ST_SYNCED, ST_STROBE: begin
        if (WriteStrobe) begin
          if (hdr) begin
            col_sel_d   = WriteData[8 +: ColumnSelectWidth];
            frame_sel_d = WriteData[0 +: FrameSelectWidth];
            row_cnt_d   = FirstRow;
          end else if (!is_sync && !is_desync) begin
            error_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        // SYNC/DESYNC patterns are ordinary data here.
        if (WriteStrobe) begin
          frame_data_d = WriteData;
          row_sel_d    = row_cnt_q;
          row_cnt_d    = row_cnt_q + FirstRow;
        end
      end
      default: ;
    endcase
  end

  assign Synced = (state_q != ST_IDLE);

`ifdef FRAME_LOADER_FRAMECNT_EN
  logic [15:0] frame_count_q;

  // Counts alongside the strobe so FrameCount already reflects a frame in its strobe cycle.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      frame_count_q <= '0;
    end else if (frame_strobe_d && (frame_count_q != 16'hFFFF)) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign FrameCount = frame_count_q;
`endif

endmodule
